// File: rtl/word_distributor.sv
// word_distributor
//   Accepts a stream of DW-bit words over a valid/ready handshake and stores
//   each one into one of 32 channel registers. A transaction starts at
//   channel `sel` and writes len+1 words with auto-increment. The channel
//   index wraps from 31 to 0. Each channel also carries a valid flag, which
//   is set by a write and cleared by `clr`.
//
// Ports
//   clk, rst_n  : clock; asynchronous active-low reset
//   en          : block enable; gates transaction start and data acceptance
//   start       : request a transaction (sampled only in IDLE)
//   sel, len    : first channel and length-minus-one, latched with start
//   din         : data word
//   din_valid   : din holds a valid word
//   din_ready   : the block accepts din this cycle
//   clr         : per-channel clear of q_valid
//   q           : channel registers; channel k sits at q[k*DW +: DW]
//   q_valid     : per-channel written-since-clear flags
//   busy        : a transaction is in progress
//   done        : one-cycle pulse after the final word is stored
module word_distributor #(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [4:0]       sel,
  input  logic [4:0]       len,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      clr,
  output logic [32*DW-1:0] q,
  output logic [31:0]      q_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [4:0]    rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] mem_q [32];
  logic [DW-1:0] mem_d [32];
  logic [31:0]   valid_q, valid_d;
  logic          fire;

  // din_ready is combinational from state and en only, so din/din_valid
  // never reach an output combinationally.
  assign din_ready = (state_q == XFER) && en;
  assign fire      = din_ready && din_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    // Clear first, so that a write to the same channel at this edge wins.
    valid_d = valid_q & ~clr;

    case (state_q)
      IDLE: begin
        if (start && en) begin
          ptr_d   = sel;
          rem_d   = len;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (fire) begin
          mem_d[ptr_q]   = din;
          valid_d[ptr_q] = 1'b1;
          ptr_d          = ptr_q + 5'd1;  // 5-bit add wraps 31 -> 0
          if (rem_q == 5'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mem_q   <= '{default: '0};
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_q
    assign q[k*DW +: DW] = mem_q[k];
  end

  assign q_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_word_distributor.sv
module tb_word_distributor;

  localparam int unsigned DW = 32;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             start;
  logic [4:0]       sel;
  logic [4:0]       len;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic             din_ready;
  logic [31:0]      clr;
  logic [32*DW-1:0] q;
  logic [31:0]      q_valid;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;

  word_distributor #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .sel       (sel),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .clr       (clr),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_at(input int k);
    return q[k*DW +: DW];
  endfunction

  // Reset the DUT; returns at a falling edge with rst_n released.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; start = 1'b0; sel = '0; len = '0;
    din = '0; din_valid = 1'b0; clr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Back-to-back burst with din = base + word index. Returns the number of
  // falling edges after the start edge at which done was first seen.
  task automatic do_burst(input logic [4:0] s, input logic [4:0] l,
                          input logic [31:0] base, output int cycles);
    int  sent;
    logic hs;
    sent = 0;
    cycles = 0;
    @(negedge clk);
    start = 1'b1; sel = s; len = l; en = 1'b1;
    din = base; din_valid = 1'b1;
    hs = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs) begin
        sent++;
        din = base + sent;
      end
      if (done) begin
        cycles = i;
        break;
      end
      hs = din_ready && din_valid;
    end
    din_valid = 1'b0;
    if (cycles == 0) begin
      miscompares++;
      $display("FAIL burst_timeout: done not seen within 64 cycles (sel=%0d len=%0d)", s, l);
    end
  endtask

  task automatic test_reset();
    bit bad;
    apply_reset();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (din_ready !== 1'b0) begin miscompares++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
    vectors++;
    if (q_valid !== 32'h0) begin miscompares++; $display("FAIL reset_q_valid: got %h want 00000000", q_valid); end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) if (word_at(k) !== 32'h0) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL reset_q: q not all zero"); end
    // start with en=0 must be ignored
    @(negedge clk);
    en = 1'b0; start = 1'b1; sel = 5'd3;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL start_no_en: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit bad;
    apply_reset();
    @(negedge clk);
    start = 1'b1; sel = 5'd7; len = 5'd0; din = 32'hDEADBEEF; din_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
    vectors++;
    if (din_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", din_ready); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_early: got %b want 0", done); end
    @(negedge clk);
    din_valid = 1'b0;
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL single_done: got %b want 1", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", busy); end
    vectors++;
    if (word_at(7) !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_q7: got %h want deadbeef", word_at(7)); end
    vectors++;
    if (q_valid !== 32'h00000080) begin miscompares++; $display("FAIL single_q_valid: got %h want 00000080", q_valid); end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) if (k != 7 && word_at(k) !== 32'h0) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL single_others: other channels not zero"); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_wrap();
    int c;
    apply_reset();
    do_burst(5'd30, 5'd3, 32'h1, c);
    vectors++;
    if (c != 5) begin miscompares++; $display("FAIL wrap_latency: done at cycle %0d want 5", c); end
    vectors++;
    if (word_at(30) !== 32'h1 || word_at(31) !== 32'h2 || word_at(0) !== 32'h3 || word_at(1) !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_data: q30=%h q31=%h q0=%h q1=%h want 1 2 3 4",
               word_at(30), word_at(31), word_at(0), word_at(1));
    end
    vectors++;
    if (q_valid !== 32'hC0000003) begin miscompares++; $display("FAIL wrap_q_valid: got %h want c0000003", q_valid); end
    // clr in IDLE drops flags but keeps data
    @(negedge clk);
    clr = 32'h80000001;
    @(negedge clk);
    clr = '0;
    vectors++;
    if (q_valid !== 32'h40000002 || word_at(31) !== 32'h2) begin
      miscompares++;
      $display("FAIL idle_clr: q_valid=%h q31=%h want 40000002 / 2", q_valid, word_at(31));
    end
  endtask

  task automatic test_stall();
    apply_reset();
    @(negedge clk);                                   // n0
    start = 1'b1; sel = 5'd0; len = 5'd2; din = 32'hA0; din_valid = 1'b1;
    @(negedge clk);                                   // n1, after start edge
    start = 1'b0;
    @(negedge clk);                                   // n2, A0 written
    din_valid = 1'b0; din = 32'hA1;
    vectors++;
    if (word_at(0) !== 32'hA0) begin miscompares++; $display("FAIL stall_first: got %h want a0", word_at(0)); end
    repeat (3) @(negedge clk);                        // n3..n5, valid low
    vectors++;
    if (q_valid !== 32'h1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL stall_gap: q_valid=%h busy=%b want 1/1", q_valid, busy);
    end
    en = 1'b0; din_valid = 1'b1;
    #1;
    vectors++;
    if (din_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_en0: got %b want 0", din_ready); end
    repeat (2) @(negedge clk);                        // n6, n7
    vectors++;
    if (q_valid !== 32'h1 || word_at(1) !== 32'h0 || din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_en_gap: q_valid=%h q1=%h ready=%b want 1/0/0", q_valid, word_at(1), din_ready);
    end
    en = 1'b1;
    @(negedge clk);                                   // A1 written
    din = 32'hA2;
    vectors++;
    if (done !== 1'b0 || word_at(1) !== 32'hA1) begin
      miscompares++; $display("FAIL stall_second: done=%b q1=%h want 0/a1", done, word_at(1));
    end
    @(negedge clk);                                   // A2 written
    din_valid = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL stall_done: done=%b busy=%b want 1/0", done, busy);
    end
    vectors++;
    if (word_at(0) !== 32'hA0 || word_at(1) !== 32'hA1 || word_at(2) !== 32'hA2 || q_valid !== 32'h7) begin
      miscompares++;
      $display("FAIL stall_data: q0=%h q1=%h q2=%h q_valid=%h want a0 a1 a2 7",
               word_at(0), word_at(1), word_at(2), q_valid);
    end
  endtask

  task automatic test_full_bank();
    int c;
    bit bad;
    apply_reset();
    do_burst(5'd5, 5'd31, 32'h0, c);
    vectors++;
    if (c != 33) begin miscompares++; $display("FAIL full_latency: done at cycle %0d want 33", c); end
    vectors++;
    if (q_valid !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL full_q_valid: got %h want ffffffff", q_valid); end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) if (word_at(k) !== 32'((k + 27) % 32)) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL full_data: channel contents not index order"); end
    vectors++;
    if (word_at(4) !== 32'd31) begin miscompares++; $display("FAIL full_last: q4=%h want 1f", word_at(4)); end
  endtask

  // Runs on the bank left by test_full_bank.
  task automatic test_clr_collision();
    bit bad;
    @(negedge clk);
    start = 1'b1; sel = 5'd9; len = 5'd0; din = 32'h99; din_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 32'hFFFFFFFF;
    @(negedge clk);
    clr = '0; din_valid = 1'b0;
    vectors++;
    if (q_valid !== 32'h00000200) begin miscompares++; $display("FAIL clr_q_valid: got %h want 00000200", q_valid); end
    vectors++;
    if (word_at(9) !== 32'h99 || done !== 1'b1) begin
      miscompares++; $display("FAIL clr_write: q9=%h done=%b want 99/1", word_at(9), done);
    end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) if (k != 9 && word_at(k) !== 32'((k + 27) % 32)) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL clr_data: unaddressed channel data changed"); end
  endtask

  task automatic test_reset_mid_burst();
    int  c;
    bit  bad;
    apply_reset();
    @(negedge clk);
    start = 1'b1; sel = 5'd3; len = 5'd7; din = 32'h50; din_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    din = 32'h51;
    @(negedge clk);                                   // two words stored
    din = 32'h52;
    vectors++;
    if (q_valid !== 32'h18) begin miscompares++; $display("FAIL mid_pre: q_valid=%h want 00000018", q_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || q_valid !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b ready=%b q_valid=%h want 0/0/0", busy, din_ready, q_valid);
    end
    bad = 1'b0;
    for (int k = 0; k < 32; k++) if (word_at(k) !== 32'h0) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL mid_reset_q: q not cleared"); end
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_burst(5'd12, 5'd1, 32'h70, c);
    vectors++;
    if (c != 3 || word_at(12) !== 32'h70 || word_at(13) !== 32'h71 || q_valid !== 32'h00003000) begin
      miscompares++;
      $display("FAIL mid_restart: cyc=%0d q12=%h q13=%h q_valid=%h want 3 70 71 00003000",
               c, word_at(12), word_at(13), q_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; sel = '0; len = '0;
    din = '0; din_valid = 1'b0; clr = '0;
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_full_bank();
    test_clr_collision();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
